tx_ts_buffer: RTL and testbench

Parametrised successor to the gPTP transmit buffer. gPTP software writes frame descriptors into a slot memory. A small pending queue lets up to QDEPTH slots wait for transmission instead of one at a time. The block hands each queued slot to the MAC, then waits for the hardware egress timestamp and overwrites the slot with it. A timeout and a per-completion status report a timestamp that never comes back.

---
 rtl/tx_ts_buffer_if.sv | 39 +++
 rtl/tx_ts_buffer.sv | 167 ++++++++++++++++
 tb/tb_tx_ts_buffer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_ts_buffer_if.sv
// Bus bundle for tx_ts_buffer: gPTP write/read/completion, MAC offer/timestamp and statistics.
// The master side drives requests and MAC responses; the buffer attaches to the slave side.
interface tx_ts_buffer_if #(
    parameter int unsigned DATA_W = 80,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] gptp_wr_addr;
    logic [DATA_W-1:0] gptp_wr_data;
    logic              gptp_wr_vaild;
    logic              gptp_wr_ready;
    logic [ADDR_W-1:0] gptp_rd_addr;
    logic [DATA_W-1:0] gptp_rd_data;
    logic              gptp_ts_done;
    logic [ADDR_W-1:0] gptp_ts_addr;
    logic              gptp_ts_err;
    logic [ADDR_W-1:0] send_addr;
    logic [DATA_W-1:0] send_data;
    logic              send_vaild;
    logic              send_ready;
    logic              send_r_vaild;
    logic [DATA_W-1:0] send_r_data;
    logic [CNT_W-1:0]  ts_drop_cnt;
    logic [CNT_W-1:0]  ts_tmo_cnt;

    modport master (
        output gptp_wr_addr, gptp_wr_data, gptp_wr_vaild, gptp_rd_addr,
        output send_ready, send_r_vaild, send_r_data,
        input  gptp_wr_ready, gptp_rd_data, gptp_ts_done, gptp_ts_addr, gptp_ts_err,
        input  send_addr, send_data, send_vaild, ts_drop_cnt, ts_tmo_cnt
    );

    modport slave (
        input  gptp_wr_addr, gptp_wr_data, gptp_wr_vaild, gptp_rd_addr,
        input  send_ready, send_r_vaild, send_r_data,
        output gptp_wr_ready, gptp_rd_data, gptp_ts_done, gptp_ts_addr, gptp_ts_err,
        output send_addr, send_data, send_vaild, ts_drop_cnt, ts_tmo_cnt
    );
endinterface

// File: rtl/tx_ts_buffer.sv
// gPTP transmit timestamp buffer: slot memory, pending-slot queue, MAC offer and
// timestamp writeback with timeout and saturating drop/timeout statistics.
module tx_ts_buffer #(
    parameter int unsigned DATA_W     = 80,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned TS_TIMEOUT = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input logic           clk,
    input logic           reset,
    tx_ts_buffer_if.slave bus
);
    localparam int unsigned NSLOT = 1 << ADDR_W;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned TMR_W = $clog2(TS_TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] WAIT_TS = 2'd2;

    logic [DATA_W-1:0] mem_q [NSLOT];
    logic [ADDR_W-1:0] q_mem_q [QDEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] send_addr_q, send_addr_d;
    logic [DATA_W-1:0] send_data_q, send_data_d;
    logic              send_vaild_q, send_vaild_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] ts_addr_q, ts_addr_d;
    logic              ts_err_q, ts_err_d;
    logic [CNT_W-1:0]  drop_q, drop_d, tmo_q, tmo_d;
    logic [DATA_W-1:0] rd_data_q;

    logic wr_acc, pop, ts_wb;

    assign wr_acc = bus.gptp_wr_vaild && !full_q;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        timer_d      = timer_q;
        send_addr_d  = send_addr_q;
        send_data_d  = send_data_q;
        send_vaild_d = send_vaild_q;
        done_d       = 1'b0;
        ts_addr_d    = ts_addr_q;
        ts_err_d     = ts_err_q;
        tmo_d        = tmo_q;
        drop_d       = drop_q;
        pop          = 1'b0;
        ts_wb        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop          = 1'b1;
                    cur_addr_d   = q_mem_q[rptr_q];
                    send_addr_d  = q_mem_q[rptr_q];
                    send_data_d  = mem_q[q_mem_q[rptr_q]];
                    send_vaild_d = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (bus.send_ready) begin
                    send_vaild_d = 1'b0;
                    timer_d      = '0;
                    state_d      = WAIT_TS;
                end
            end
            WAIT_TS: begin
                // A timestamp on the final timer cycle still counts as a success.
                if (bus.send_r_vaild) begin
                    ts_wb     = 1'b1;
                    done_d    = 1'b1;
                    ts_addr_d = cur_addr_q;
                    ts_err_d  = 1'b0;
                    state_d   = IDLE;
                end else if (timer_q == TMR_W'(TS_TIMEOUT - 1)) begin
                    done_d    = 1'b1;
                    ts_addr_d = cur_addr_q;
                    ts_err_d  = 1'b1;
                    if (tmo_q != '1) tmo_d = tmo_q + CNT_W'(1);
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.send_r_vaild && state_q != WAIT_TS && drop_q != '1) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_comb begin
        wptr_d = wptr_q + PTR_W'(wr_acc);
        rptr_d = rptr_q + PTR_W'(pop);
        cnt_d  = cnt_q + (PTR_W + 1)'(wr_acc) - (PTR_W + 1)'(pop);
        full_d = (cnt_d == (PTR_W + 1)'(QDEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            timer_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            send_addr_q  <= '0;
            send_data_q  <= '0;
            send_vaild_q <= 1'b0;
            done_q       <= 1'b0;
            ts_addr_q    <= '0;
            ts_err_q     <= 1'b0;
            drop_q       <= '0;
            tmo_q        <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            timer_q      <= timer_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            send_addr_q  <= send_addr_d;
            send_data_q  <= send_data_d;
            send_vaild_q <= send_vaild_d;
            done_q       <= done_d;
            ts_addr_q    <= ts_addr_d;
            ts_err_q     <= ts_err_d;
            drop_q       <= drop_d;
            tmo_q        <= tmo_d;
            rd_data_q    <= mem_q[bus.gptp_rd_addr];
        end
    end

    // Slot and queue storage are not reset; the timestamp write comes last so it wins a collision.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[bus.gptp_wr_addr] <= bus.gptp_wr_data;
            q_mem_q[wptr_q]         <= bus.gptp_wr_addr;
        end
        if (reset && ts_wb) begin
            mem_q[cur_addr_q] <= bus.send_r_data;
        end
    end

    assign bus.gptp_wr_ready = !full_q;
    assign bus.gptp_rd_data  = rd_data_q;
    assign bus.gptp_ts_done  = done_q;
    assign bus.gptp_ts_addr  = ts_addr_q;
    assign bus.gptp_ts_err   = ts_err_q;
    assign bus.send_addr     = send_addr_q;
    assign bus.send_data     = send_data_q;
    assign bus.send_vaild    = send_vaild_q;
    assign bus.ts_drop_cnt   = drop_q;
    assign bus.ts_tmo_cnt    = tmo_q;
endmodule

// File: tb/tb_tx_ts_buffer.sv
// Bench for tx_ts_buffer: directed scenarios then random traffic, every cycle checked
// against a transaction-level model (slot array, pending queue, busy/waiting flags).
module tb_tx_ts_buffer;
    localparam int unsigned DATA_W     = 80;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned QDEPTH     = 4;
    localparam int unsigned TS_TIMEOUT = 24;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned NSLOT      = 1 << ADDR_W;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tx_ts_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    tx_ts_buffer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .TS_TIMEOUT(TS_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] m_mem [NSLOT];
    bit                m_known [NSLOT];
    logic [ADDR_W-1:0] mq [$];
    bit                m_busy, m_wait, m_sdata_known, m_rd_known, m_done, m_err;
    int                m_timer, m_drop, m_tmo;
    logic [ADDR_W-1:0] m_cur, m_taddr;
    logic [DATA_W-1:0] m_sdata, m_rd;

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.gptp_wr_vaild = 1'b0;
        bus.gptp_wr_addr  = '0;
        bus.gptp_wr_data  = '0;
        bus.send_ready    = 1'b0;
        bus.send_r_vaild  = 1'b0;
        bus.send_r_data   = '0;
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, compare all outputs.
    task automatic step();
        bit acc, wb, rv;
        @(posedge clk);
        rv  = bus.send_r_vaild;
        acc = bus.gptp_wr_vaild && (mq.size() < QDEPTH);
        wb  = 1'b0;
        if (!reset) begin
            mq.delete();
            m_busy = 0; m_wait = 0; m_cur = '0; m_sdata = '0; m_sdata_known = 1;
            m_done = 0; m_err = 0; m_taddr = '0; m_drop = 0; m_tmo = 0;
            m_rd = '0; m_rd_known = 1;
        end else begin
            m_rd       = m_mem[bus.gptp_rd_addr];
            m_rd_known = m_known[bus.gptp_rd_addr];
            m_done     = 0;
            if (m_busy && m_wait) begin
                if (rv) begin
                    wb = 1; m_done = 1; m_err = 0; m_taddr = m_cur; m_busy = 0;
                end else if (m_timer == TS_TIMEOUT - 1) begin
                    m_done = 1; m_err = 1; m_taddr = m_cur; m_busy = 0;
                    if (m_tmo < CNT_MAX) m_tmo++;
                end else begin
                    m_timer++;
                end
            end else begin
                if (rv && m_drop < CNT_MAX) m_drop++;
                if (m_busy && bus.send_ready) begin
                    m_wait = 1; m_timer = 0;
                end else if (!m_busy && mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_sdata = m_mem[m_cur];
                    m_sdata_known = m_known[m_cur];
                    m_busy = 1; m_wait = 0;
                end
            end
            if (acc) begin
                m_mem[bus.gptp_wr_addr]   = bus.gptp_wr_data;
                m_known[bus.gptp_wr_addr] = 1;
                mq.push_back(bus.gptp_wr_addr);
            end
            if (wb) begin
                m_mem[m_cur]   = bus.send_r_data;
                m_known[m_cur] = 1;
            end
        end
        #1;
        chk("send_vaild", bus.send_vaild, m_busy && !m_wait);
        chk("send_addr", bus.send_addr, m_cur);
        if (m_sdata_known) chk("send_data", bus.send_data, m_sdata);
        chk("ts_done", bus.gptp_ts_done, m_done);
        chk("ts_addr", bus.gptp_ts_addr, m_taddr);
        chk("ts_err", bus.gptp_ts_err, m_err);
        chk("wr_ready", bus.gptp_wr_ready, mq.size() < QDEPTH);
        if (m_rd_known) chk("rd_data", bus.gptp_rd_data, m_rd);
        chk("drop_cnt", bus.ts_drop_cnt, m_drop);
        chk("tmo_cnt", bus.ts_tmo_cnt, m_tmo);
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.gptp_wr_vaild = 1'b1;
        bus.gptp_wr_addr  = a;
        bus.gptp_wr_data  = d;
        step();
        bus.gptp_wr_vaild = 1'b0;
    endtask

    task automatic wait_offer(input int lim);
        int n = 0;
        while (!bus.send_vaild && n < lim) begin
            step();
            n++;
        end
        chk("offer_wait", bus.send_vaild, 1'b1);
    endtask

    task automatic handshake();
        bus.send_ready = 1'b1;
        step();
        bus.send_ready = 1'b0;
    endtask

    task automatic return_ts(input logic [DATA_W-1:0] ts);
        bus.send_r_vaild = 1'b1;
        bus.send_r_data  = ts;
        step();
        bus.send_r_vaild = 1'b0;
    endtask

    logic [DATA_W-1:0] d7;

    initial begin
        for (int i = 0; i < NSLOT; i++) m_known[i] = 0;
        idle_in();
        bus.gptp_rd_addr = '0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_ready", bus.gptp_wr_ready, 1'b1);

        // Basic flow
        write(4'd1, 80'h123456789abc00000001);
        chk("basic_early", bus.send_vaild, 1'b0);
        step();
        chk("basic_vaild", bus.send_vaild, 1'b1);
        chk("basic_addr", bus.send_addr, 4'd1);
        chk("basic_data", bus.send_data, 80'h123456789abc00000001);
        handshake();
        step();
        return_ts(80'h123456789abc00000002);
        chk("basic_done", bus.gptp_ts_done, 1'b1);
        chk("basic_taddr", bus.gptp_ts_addr, 4'd1);
        chk("basic_err", bus.gptp_ts_err, 1'b0);
        bus.gptp_rd_addr = 4'd1;
        step();
        chk("basic_rd", bus.gptp_rd_data, 80'h123456789abc00000002);

        // Backpressure: 4 queued plus 1 held in SEND
        for (int i = 1; i <= 5; i++) write(ADDR_W'(i), rnd_data());
        chk("bp_full", bus.gptp_wr_ready, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            wait_offer(8);
            chk("bp_order", bus.send_addr, ADDR_W'(i));
            handshake();
            return_ts(rnd_data());
        end

        // Timeout
        d7 = rnd_data();
        write(4'd7, d7);
        wait_offer(8);
        handshake();
        for (int i = 0; i < TS_TIMEOUT - 1; i++) step();
        chk("tmo_early", bus.gptp_ts_done, 1'b0);
        step();
        chk("tmo_done", bus.gptp_ts_done, 1'b1);
        chk("tmo_err", bus.gptp_ts_err, 1'b1);
        chk("tmo_cnt1", bus.ts_tmo_cnt, 4'd1);
        bus.gptp_rd_addr = 4'd7;
        step();
        chk("tmo_slot", bus.gptp_rd_data, d7);

        // Stray timestamp while idle
        return_ts(rnd_data());
        step();
        chk("stray_drop", bus.ts_drop_cnt, 4'd1);
        chk("stray_slot", bus.gptp_rd_data, d7);

        // Collision: timestamp and write to slot 3 on the same edge
        write(4'd3, rnd_data());
        wait_offer(8);
        handshake();
        bus.gptp_wr_vaild = 1'b1;
        bus.gptp_wr_addr  = 4'd3;
        bus.gptp_wr_data  = 80'h0000_0000_0000_dead_beef;
        return_ts(80'h5555_aaaa_0000_1111_2222);
        bus.gptp_wr_vaild = 1'b0;
        bus.gptp_rd_addr  = 4'd3;
        step();
        chk("coll_rd", bus.gptp_rd_data, 80'h5555_aaaa_0000_1111_2222);
        wait_offer(8);
        chk("coll_requeue", bus.send_addr, 4'd3);
        handshake();
        return_ts(rnd_data());

        // Reset while waiting for a timestamp
        write(4'd5, rnd_data());
        wait_offer(8);
        handshake();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_vaild", bus.send_vaild, 1'b0);
        chk("rst_done", bus.gptp_ts_done, 1'b0);
        chk("rst_drop", bus.ts_drop_cnt, 4'd0);
        for (int i = 0; i < 4; i++) step();
        write(4'd2, rnd_data());
        wait_offer(8);
        chk("rst_after", bus.send_addr, 4'd2);
        handshake();
        return_ts(rnd_data());
        chk("rst_after_done", bus.gptp_ts_done, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < CNT_MAX + 4; i++) return_ts(rnd_data());
        chk("drop_sat", bus.ts_drop_cnt, 4'hf);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.gptp_wr_vaild = ($urandom_range(0, 1) == 1);
            bus.gptp_wr_addr  = ADDR_W'($urandom_range(0, 7));
            bus.gptp_wr_data  = rnd_data();
            bus.send_ready    = ($urandom_range(0, 2) == 0);
            bus.send_r_vaild  = ($urandom_range(0, 15) == 0);
            bus.send_r_data   = rnd_data();
            bus.gptp_rd_addr  = ADDR_W'($urandom_range(0, 7));
            step();
        end
        idle_in();
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
